// File: rtl/sc_inst_encoder.sv
// sc_inst_encoder: packs mnemonic-level commands into 32-bit MIPS words for
// the single-cycle core and streams them into instruction memory at an
// auto-incrementing word address. The li pseudo-instruction expands into a
// lui/ori pair; illegal mnemonics are swallowed and flagged with bad_opc.
module sc_inst_encoder #(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opc,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_sa,
  input  logic [31:0]       in_imm,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              bad_opc,
  output logic              wrapped
);

  localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(BASE_ADDR);

  // Mnemonic codes on in_opc
  localparam logic [4:0] OPC_ADD  = 5'd0;
  localparam logic [4:0] OPC_SUB  = 5'd1;
  localparam logic [4:0] OPC_AND  = 5'd2;
  localparam logic [4:0] OPC_OR   = 5'd3;
  localparam logic [4:0] OPC_XOR  = 5'd4;
  localparam logic [4:0] OPC_HAM  = 5'd5;
  localparam logic [4:0] OPC_SLL  = 5'd6;
  localparam logic [4:0] OPC_SRL  = 5'd7;
  localparam logic [4:0] OPC_SRA  = 5'd8;
  localparam logic [4:0] OPC_JR   = 5'd9;
  localparam logic [4:0] OPC_ADDI = 5'd10;
  localparam logic [4:0] OPC_ANDI = 5'd11;
  localparam logic [4:0] OPC_ORI  = 5'd12;
  localparam logic [4:0] OPC_XORI = 5'd13;
  localparam logic [4:0] OPC_LW   = 5'd14;
  localparam logic [4:0] OPC_SW   = 5'd15;
  localparam logic [4:0] OPC_BEQ  = 5'd16;
  localparam logic [4:0] OPC_BNE  = 5'd17;
  localparam logic [4:0] OPC_LUI  = 5'd18;
  localparam logic [4:0] OPC_J    = 5'd19;
  localparam logic [4:0] OPC_JAL  = 5'd20;
  localparam logic [4:0] OPC_LI   = 5'd21;
  localparam logic [4:0] OPC_NOP  = 5'd22;

  typedef enum logic {S_IDLE, S_LI2} state_t;

  state_t              r_state;
  logic                r_wr_en;
  logic [31:0]         r_wr_data;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic                r_bad_opc;
  logic                r_wrapped;
  logic [4:0]          r_li_rt;
  logic [15:0]         r_li_lo;

  logic                w_in_ready;
  logic                w_accept;
  logic                w_consume;
  logic [31:0]         w_word;
  logic                w_illegal;
  logic                w_is_li;

  assign w_in_ready = (r_state == S_IDLE) & (~r_wr_en | wr_ready);
  assign w_accept   = in_valid & w_in_ready;
  assign w_consume  = r_wr_en & wr_ready;

  assign in_ready = w_in_ready;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign bad_opc  = r_bad_opc;
  assign wrapped  = r_wrapped;

  // Encode the presented command into its first (or only) instruction word
  always_comb begin
    w_word    = 32'h0;
    w_illegal = 1'b0;
    w_is_li   = 1'b0;
    case (in_opc)
      OPC_ADD:  w_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h20};
      OPC_SUB:  w_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h22};
      OPC_AND:  w_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h24};
      OPC_OR:   w_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h25};
      OPC_XOR:  w_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h26};
      OPC_HAM:  w_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h31};
      // Shifts take their operand from rt; rs is not part of the encoding
      OPC_SLL:  w_word = {6'h00, 5'd0, in_rt, in_rd, in_sa, 6'h00};
      OPC_SRL:  w_word = {6'h00, 5'd0, in_rt, in_rd, in_sa, 6'h02};
      OPC_SRA:  w_word = {6'h00, 5'd0, in_rt, in_rd, in_sa, 6'h03};
      OPC_JR:   w_word = {6'h00, in_rs, 5'd0, 5'd0, 5'd0, 6'h08};
      OPC_ADDI: w_word = {6'h08, in_rs, in_rt, in_imm[15:0]};
      OPC_ANDI: w_word = {6'h0C, in_rs, in_rt, in_imm[15:0]};
      OPC_ORI:  w_word = {6'h0D, in_rs, in_rt, in_imm[15:0]};
      OPC_XORI: w_word = {6'h0E, in_rs, in_rt, in_imm[15:0]};
      OPC_LW:   w_word = {6'h23, in_rs, in_rt, in_imm[15:0]};
      OPC_SW:   w_word = {6'h2B, in_rs, in_rt, in_imm[15:0]};
      OPC_BEQ:  w_word = {6'h04, in_rs, in_rt, in_imm[15:0]};
      OPC_BNE:  w_word = {6'h05, in_rs, in_rt, in_imm[15:0]};
      OPC_LUI:  w_word = {6'h0F, 5'd0, in_rt, in_imm[15:0]};
      OPC_J:    w_word = {6'h02, in_imm[25:0]};
      OPC_JAL:  w_word = {6'h03, in_imm[25:0]};
      // li starts with the lui of the upper half; the ori follows from LI2
      OPC_LI: begin
        w_word  = {6'h0F, 5'd0, in_rt, in_imm[31:16]};
        w_is_li = 1'b1;
      end
      OPC_NOP:  w_word = 32'h0;
      default:  w_illegal = 1'b1;
    endcase
  end

  // Output word register, address counter and li sequencing FSM
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_wr_en   <= 1'b0;
      r_wr_data <= 32'h0;
      r_wr_addr <= LP_BASE;
      r_bad_opc <= 1'b0;
      r_wrapped <= 1'b0;
      r_li_rt   <= 5'd0;
      r_li_lo   <= 16'h0;
    end else if (restart) begin
      // Same as reset, but the last word stays visible on wr_data
      r_state   <= S_IDLE;
      r_wr_en   <= 1'b0;
      r_wr_addr <= LP_BASE;
      r_bad_opc <= 1'b0;
      r_wrapped <= 1'b0;
    end else begin
      r_bad_opc <= w_accept & w_illegal;
      if (w_consume) begin
        r_wr_addr <= r_wr_addr + ADDR_W'(1);
        if (&r_wr_addr) begin
          r_wrapped <= 1'b1;
        end
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept && !w_illegal) begin
            r_wr_en   <= 1'b1;
            r_wr_data <= w_word;
            if (w_is_li) begin
              r_state <= S_LI2;
              r_li_rt <= in_rt;
              r_li_lo <= in_imm[15:0];
            end
          end else if (w_consume) begin
            r_wr_en <= 1'b0;
          end
        end
        S_LI2: begin
          // lui word taken: replace it with ori rt, rt, lower half
          if (w_consume) begin
            r_wr_data <= {6'h0D, r_li_rt, r_li_rt, r_li_lo};
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_inst_encoder.sv
// Testbench for sc_inst_encoder: directed scenarios followed by randomized
// traffic, compared every cycle against a pending-word queue model.
module tb_sc_inst_encoder;

  localparam int AW   = 2;
  localparam int BASE = 0;

  logic          clock = 1'b0;
  logic          resetn, restart, in_valid, in_ready, wr_en, wr_ready;
  logic [4:0]    in_opc, in_rs, in_rt, in_rd, in_sa;
  logic [31:0]   in_imm, wr_data;
  logic [AW-1:0] wr_addr;
  logic          bad_opc, wrapped;

  sc_inst_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clock(clock), .resetn(resetn), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opc(in_opc), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_sa(in_sa), .in_imm(in_imm),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .bad_opc(bad_opc), .wrapped(wrapped)
  );

  always #5 clock = ~clock;

  // Reference tables taken from the instruction set definition
  logic [5:0] func_tab [0:9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26,
                                 6'h31, 6'h00, 6'h02, 6'h03, 6'h08};
  logic [5:0] iop_tab  [0:8] = '{6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h23,
                                 6'h2B, 6'h04, 6'h05, 6'h0F};

  // Model state: words awaiting consumption, address, flags, data register
  logic [31:0] q [$];
  int          m_addr;
  bit          m_wrap, m_bad, m_acc;
  logic [31:0] m_data;

  int          n_cmp = 0;
  int          n_err = 0;
  bit          want_v = 1'b0;
  logic [31:0] want_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Append the words a command produces to the model queue
  function automatic void push_words(input int opc, input logic [4:0] rs, rt, rd, sa,
                                     input logic [31:0] imm);
    logic [4:0] s_rs, s_rt, s_rd, s_sa;
    logic [5:0] op;
    if (opc <= 9) begin
      s_rs = (opc >= 6 && opc <= 8) ? 5'd0 : rs;
      s_rt = (opc == 9) ? 5'd0 : rt;
      s_rd = (opc == 9) ? 5'd0 : rd;
      s_sa = (opc >= 6 && opc <= 8) ? sa : 5'd0;
      q.push_back({6'h00, s_rs, s_rt, s_rd, s_sa, func_tab[opc]});
    end else if (opc <= 18) begin
      op   = iop_tab[opc-10];
      s_rs = (opc == 18) ? 5'd0 : rs;
      q.push_back({op, s_rs, rt, imm[15:0]});
    end else if (opc <= 20) begin
      op = (opc == 19) ? 6'h02 : 6'h03;
      q.push_back({op, imm[25:0]});
    end else if (opc == 21) begin
      q.push_back({6'h0F, 5'd0, rt, imm[31:16]});
      q.push_back({6'h0D, rt, rt, imm[15:0]});
    end else if (opc == 22) begin
      q.push_back(32'h0);
    end
  endfunction

  // One clock: check outputs mid-cycle, then advance the model over the edge
  task automatic step();
    bit exp_ready, consume;
    @(negedge clock);
    exp_ready = (q.size() == 0) || (q.size() == 1 && wr_ready);
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("wr_en",    32'(wr_en),    32'(q.size() > 0));
    chk("wr_addr",  32'(wr_addr),  32'(m_addr));
    chk("wr_data",  wr_data,       m_data);
    chk("bad_opc",  32'(bad_opc),  32'(m_bad));
    chk("wrapped",  32'(wrapped),  32'(m_wrap));
    if (want_v) begin
      chk("plan_word", wr_data, want_d);
      want_v = 1'b0;
    end
    $display("t=%0t opc=%0d v=%0b rdy=%0b | wr_en=%0b addr=%0d data=%h bad=%0b wrap=%0b",
             $time, in_opc, in_valid, in_ready, wr_en, wr_addr, wr_data, bad_opc, wrapped);
    m_acc = 1'b0;
    if (!resetn) begin
      q.delete(); m_addr = BASE; m_wrap = 0; m_bad = 0; m_data = 32'h0;
    end else if (restart) begin
      q.delete(); m_addr = BASE; m_wrap = 0; m_bad = 0;
    end else begin
      consume = (q.size() > 0) && wr_ready;
      m_acc   = in_valid && exp_ready;
      if (consume) begin
        if (m_addr == (1 << AW) - 1) m_wrap = 1'b1;
        m_addr = (m_addr + 1) % (1 << AW);
        void'(q.pop_front());
      end
      m_bad = m_acc && (int'(in_opc) >= 23);
      if (m_acc) push_words(int'(in_opc), in_rs, in_rt, in_rd, in_sa, in_imm);
      if (q.size() > 0) m_data = q[0];
    end
    @(posedge clock);
    #1;
  endtask

  task automatic set_cmd(input int opc, input int rs, input int rt, input int rd,
                         input int sa, input logic [31:0] imm);
    in_valid = 1'b1;
    in_opc = 5'(opc); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd); in_sa = 5'(sa);
    in_imm = imm;
  endtask

  task automatic expect_word(input logic [31:0] w);
    want_v = 1'b1;
    want_d = w;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; resetn = 1'b0; restart = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; restart = 1'b0; in_valid = 1'b0; wr_ready = 1'b1;
    in_opc = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_sa = '0; in_imm = '0;
    // Let reset take hold before the first comparison
    repeat (2) @(posedge clock);
    #1;
    q.delete(); m_addr = BASE; m_wrap = 0; m_bad = 0; m_data = 32'h0; m_acc = 0;
    do_reset();

    // add rs=1 rt=2 rd=3
    set_cmd(0, 1, 2, 3, 0, 32'h0); step();
    in_valid = 1'b0; expect_word(32'h00221820); step();
    step();

    // hamming then sll back to back
    set_cmd(5, 5, 6, 4, 0, 32'h0); step();
    set_cmd(6, 7, 3, 2, 4, 32'h0); expect_word(32'h00A62031); step();
    in_valid = 1'b0; expect_word(32'h00031100); step();
    step();

    // li with a second command held on in_valid
    set_cmd(21, 0, 8, 0, 0, 32'h12345678); step();
    set_cmd(1, 9, 10, 11, 0, 32'h0); expect_word(32'h3C081234); step();
    expect_word(32'h35085678); step();
    in_valid = 1'b0; step();
    step();

    // beq held under back-pressure, j waiting behind it
    set_cmd(16, 1, 2, 0, 0, 32'h0000FFFF); step();
    set_cmd(19, 0, 0, 0, 0, 32'h00000010); wr_ready = 1'b0;
    repeat (3) begin expect_word(32'h1022FFFF); step(); end
    wr_ready = 1'b1; expect_word(32'h1022FFFF); step();
    in_valid = 1'b0; expect_word(32'h08000010); step();
    step();

    // Five nops through the address wrap, then an illegal mnemonic
    do_reset();
    set_cmd(22, 0, 0, 0, 0, 32'h0);
    repeat (5) step();
    in_valid = 1'b0; step(); step();
    set_cmd(25, 3, 3, 3, 3, 32'hFFFFFFFF); step();
    in_valid = 1'b0; step(); step();

    // Reset while the lui word is stalled in LI2
    do_reset();
    set_cmd(21, 0, 3, 0, 0, 32'hDEADBEEF); step();
    in_valid = 1'b0; wr_ready = 1'b0; step();
    resetn = 1'b0; step();
    resetn = 1'b1; wr_ready = 1'b1; step(); step();

    // restart in the middle of a stream with a command offered
    set_cmd(12, 1, 2, 0, 0, 32'h0000ABCD); repeat (3) step();
    restart = 1'b1; step();
    restart = 1'b0; set_cmd(13, 4, 5, 0, 0, 32'h00001234); step();
    in_valid = 1'b0; step(); step();

    // Randomized traffic, including illegal codes, restarts and resets
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_opc   = 5'($urandom_range(0, 31));
      in_rs    = 5'($urandom); in_rt = 5'($urandom);
      in_rd    = 5'($urandom); in_sa = 5'($urandom);
      in_imm   = $urandom;
      wr_ready = ($urandom_range(0, 9) < 7);
      restart  = ($urandom_range(0, 49) == 0);
      resetn   = ($urandom_range(0, 99) != 0);
      step();
    end
    resetn = 1'b1; restart = 1'b0; in_valid = 1'b0; wr_ready = 1'b1;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sc_inst_encoder.md
Name: sc_inst_encoder

Overview:
- Hardware instruction encoder for the single-cycle MIPS core; the writer-side counterpart of the control unit's op/func decoder.
- Accepts mnemonic-level commands with register, shift and immediate fields over a valid/ready handshake.
- Packs each command into a 32-bit MIPS word using the exact op/func codes the core decodes, including the custom hamming R-type (func 110001).
- Streams words into instruction memory at an auto-incrementing word address. Expands the `li` pseudo-instruction into two words.

Parameters:
- ADDR_W, 6: instruction-memory word-address width.
- BASE_ADDR, 0: address of the first word after reset or restart.

Ports:
- clock  in  1  single clock; all state updates on rising edge
- resetn  in  1  synchronous, active-low reset
- restart  in  1  sync pulse: wr_addr <= BASE_ADDR, wrapped <= 0, FSM -> IDLE, wr_en <= 0
- in_valid  in  1  command valid
- in_ready  out  1  encoder can accept a command this cycle
- in_opc  in  5  mnemonic code (see Behaviour)
- in_rs  in  5  rs field
- in_rt  in  5  rt field
- in_rd  in  5  rd field
- in_sa  in  5  shift amount
- in_imm  in  32  imm16 = [15:0]; J target = [25:0]; li constant = [31:0]
- wr_en  out  1  word valid toward memory
- wr_ready  in  1  memory accepts word
- wr_addr  out  ADDR_W  word address of wr_data
- wr_data  out  32  encoded instruction
- bad_opc  out  1  one-cycle pulse when an illegal in_opc is handshaken
- wrapped  out  1  sticky; set when wr_addr wraps from all-ones to 0

Behaviour:
- Reset (resetn=0 at an edge):
  - wr_en=0, wr_data=0, wr_addr=BASE_ADDR, bad_opc=0, wrapped=0, FSM=IDLE.
  - Reset mid-li abandons the second word.
  - restart has identical effect on these registers, except wr_data, which it leaves unchanged.
- Opcodes:
  - R-type: 0 add(20h), 1 sub(22h), 2 and(24h), 3 or(25h), 4 xor(26h), 5 hamming(31h), 6 sll(00h), 7 srl(02h), 8 sra(03h), 9 jr(08h).
  - I-type: 10 addi(08h), 11 andi(0Ch), 12 ori(0Dh), 13 xori(0Eh), 14 lw(23h), 15 sw(2Bh), 16 beq(04h), 17 bne(05h), 18 lui(0Fh).
  - J-type: 19 j(02h), 20 jal(03h).
  - Pseudo: 21 li, 22 nop.
  - 23-31 illegal.
- Packing:
  - R: {6'b0, rs, rt, rd, sa, func}.
  - Shifts force rs=0.
  - jr forces rt=rd=sa=0.
  - Non-shift R forces sa=0.
  - I: {op, rs, rt, imm[15:0]}. lui forces rs=0.
  - J: {op, imm[25:0]}.
  - nop = 32'h0.
  - li: word1 = lui rt, imm[31:16]; word2 = ori rt, rt, imm[15:0]. Always two words, even when the upper or lower half is zero.
- Handshake:
  - A command is accepted when in_valid & in_ready.
  - in_ready = (state==IDLE) & (~wr_en | wr_ready).
  - A word is consumed when wr_en & wr_ready.
  - wr_data and wr_addr are stable while wr_en & ~wr_ready.
- Latency: the encoded word appears with wr_en=1 on the cycle after acceptance.
  - Back-to-back accept with wr_ready=1 sustains one word per cycle.
  - wr_en deasserts after consumption when no new word is loaded.
- FSM:
  - IDLE --accept li--> LI2. Output = lui word; lower half and rt are latched.
  - LI2: in_ready=0. When the lui word is consumed, the ori word is loaded (wr_en stays 1) and the FSM returns to IDLE.
- Address: wr_addr increments by 1, modulo 2^ADDR_W, on each consumption.
  - All-ones -> 0 sets wrapped.
  - The increment coincides with loading the next word.
- Illegal opc:
  - Handshake completes.
  - No word is produced; wr_addr is unchanged.
  - bad_opc=1 for exactly the following cycle.
- Simultaneous events: resetn has priority over restart; restart has priority over handshakes in the same cycle. Commands presented in that cycle are not accepted (in_ready is still reported per formula but ignored).

Test Plan:
- Reset, then add rs=1 rt=2 rd=3 with wr_ready=1 -> next cycle wr_en=1, wr_addr=0, wr_data=0x00221820; wr_en=0 the cycle after.
- hamming rd=4 rs=5 rt=6, then sll rd=2 rt=3 sa=4 (rs=7 ignored) back-to-back -> 0x00A62031 @0, 0x00031100 @1, on consecutive cycles.
- li rt=8 imm=0x12345678 -> 0x3C081234 @0 then 0x35085678 @1; in_ready=0 during LI2; a second command held on in_valid is accepted only after the ori word is consumed.
- beq rs=1 rt=2 imm=0xFFFF, then j imm=0x10, with wr_ready low for 3 cycles -> 0x1022FFFF held stable at addr 0 for 3 cycles with in_ready=0; then 0x08000010 @1.
- ADDR_W=2: five nops -> addresses 0,1,2,3,0; wrapped rises when the word at addr 3 is consumed. Illegal opc 25 -> bad_opc pulse, no wr_en, address unchanged.
- Assert resetn=0 while in LI2 -> outputs return to reset values and the ori word is never emitted. restart during an idle stream -> next word at BASE_ADDR.
